dds_sweep_ctrl: RTL
===================

# dds_sweep_ctrl

Frequency-sweep controller that sits directly upstream of the DDS core. It generates the 32-bit frequency control word and 12-bit phase control word the core consumes, stepping from a start to a stop frequency with a programmable dwell per point, in single-shot or continuous mode. Its `Fword`/`Pword` outputs connect straight to the DDS core's inputs on the same clock.

## Interface
- `DWELL_W`, 16: width of the dwell count; each point is held `dwell+1` cycles.
- `clk` in 1: system clock; all logic on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: level-sampled; starts a sweep when in IDLE.
- `abort` in 1: stops any sweep; highest priority after reset.
- `mode` in 1: 0 = single-shot, 1 = continuous (repeat).
- `f_start` in 32: first frequency word.
- `f_stop` in 32: final frequency word.
- `f_step` in 32: increment per point.
- `dwell` in DWELL_W: cycles per point minus one.
- `p_word` in 12: phase offset, latched at start.
- `Fword` out 32: frequency word to the DDS core.
- `Pword` out 12: phase word to the DDS core.
- `busy` out 1: high in SWEEP or LAST.
- `done` out 1: one-cycle pulse when a single-shot sweep completes.
- `wrap` out 1: one-cycle pulse when a continuous sweep restarts.

## Operation
- Reset (`rst_n`=0 at an edge) sets state IDLE and `Fword`=0, `Pword`=0, `busy`=0, `done`=0, `wrap`=0. The dwell counter clears.
- `f_start`, `f_stop`, `f_step`, `dwell`, `mode` and `p_word` are captured into shadow registers when `start` is accepted. Input changes during a sweep have no effect.
- States:
  - IDLE: `start`=1 latches the config and sets `Fword`=`f_start` and `Pword`=`p_word`. If `f_start` >= `f_stop`, go to LAST with `Fword`=`f_stop`. Otherwise go to SWEEP.
  - SWEEP: the dwell counter counts 0..dwell. At count==dwell, form next = `Fword`+`f_step` at 33 bits.
    - If next >= `f_stop` or carry is set, load `Fword`=`f_stop` and go to LAST.
    - Otherwise load next and stay in SWEEP.
  - LAST: hold `f_stop` for dwell+1 cycles.
    - Then, with mode=0: go to IDLE, pulse `done`; `Fword` keeps `f_stop`.
    - With mode=1: load `Fword`=`f_start`, pulse `wrap`, go to SWEEP. `f_start` >= `f_stop` re-enters LAST instead.
- `f_step`=0 in SWEEP: `Fword` stays at `f_start` until abort (CW tone). No done pulse.
- `abort`=1 in any state: go to IDLE next edge with `busy`=0 and no `done`. `Fword`/`Pword` hold their last values.
- `abort` and `start` asserted together: abort wins and the block stays IDLE.
- `start` in SWEEP/LAST is ignored.
- `Pword` changes only on accepted `start` or reset.

## Timing
- `start` sampled at edge E0 gives `Fword`=`f_start` and `busy`=1 after E1. There is one cycle of latency.
- Each point is visible for exactly dwell+1 cycles, with no gap cycles between points.
- For an N-point single sweep, IDLE is entered after edge E1+N·(dwell+1).
  - In that cycle `done`=1 and `busy`=0. `done` is high for exactly one cycle.
- Continuous wrap: the `wrap`=1 cycle is the first cycle of `f_start` being held.
- Reset mid-sweep takes effect on the next edge; all outputs take their reset values.

## Configuration
- `SWEEP_DOWN_EN` defined: `f_start` > `f_stop` sweeps downward.
  - next = `Fword`−`f_step`; if next <= `f_stop` or a borrow occurs, clamp to `f_stop` and go to LAST.
  - `f_start`==`f_stop` goes straight to LAST.
- `SWEEP_DOWN_EN` not defined: `f_start` >= `f_stop` is a single point at `f_stop` (LAST), as described above. No subtractor is built.

## Test plan
- Single up-sweep: `f_start`=100, `f_stop`=400, `f_step`=100, `dwell`=2, `mode`=0, start at E0.
  - `Fword` = 100, 200, 300, 400, each for 3 cycles, from E1.
  - `done` pulse and `busy`=0 after E13; `Fword` stays 400.
- Clamp: 0→250, step 100, `dwell`=0 -> `Fword` = 0, 100, 200, 250, then `done`.
- Overflow: `f_start`=0xFFFF_FF00, `f_stop`=0xFFFF_FFFF, `f_step`=0x200, `dwell`=0.
  - `Fword` = 0xFFFF_FF00, then 0xFFFF_FFFF (carry clamp), then `done`.
- Continuous: `mode`=1, 0→200, step 100, `dwell`=1.
  - Sequence 0, 100, 200 repeats; `wrap` pulses on each return to 0; `done` never asserts.
- Abort/reset: `abort` during the 200 point of test 1 -> IDLE next edge, `Fword`=200, `busy`=0, no `done`.
  - `rst_n`=0 mid-sweep -> all outputs 0 next edge.
  - `start`+`abort` together in IDLE -> no sweep.
- Down sweep: 400→100, step 150.
  - With `SWEEP_DOWN_EN`: 400, 250, 100, then `done`.
  - Without `SWEEP_DOWN_EN`: 100 only, then `done`.

Source files
------------

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep controller feeding Fword/Pword to the DDS core: steps from f_start to f_stop
// with a programmable dwell per point. Optional SWEEP_DOWN_EN adds downward sweeps.
module dds_sweep_ctrl #(
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic               mode,
    input  logic [31:0]        f_start,
    input  logic [31:0]        f_stop,
    input  logic [31:0]        f_step,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [11:0]        p_word,
    output logic [31:0]        Fword,
    output logic [11:0]        Pword,
    output logic               busy,
    output logic               done,
    output logic               wrap,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        LAST  = 2'd2
    } state_t;

    state_t             state;
    logic               start_q;
    logic [DWELL_W-1:0] cnt;

    logic [31:0]        sh_start;
    logic [31:0]        sh_stop;
    logic [31:0]        sh_step;
    logic [DWELL_W-1:0] sh_dwell;
    logic               sh_mode;
    logic [11:0]        sh_pword;

    logic [32:0]        sum_up;
    logic               up_clamp;
    logic [31:0]        next_word;
    logic               next_clamp;
    logic               restart_last;
    logic               dwell_end;

    localparam logic [DWELL_W-1:0] CNT_ONE = {{(DWELL_W-1){1'b0}}, 1'b1};

    assign dbg_state = state;
    assign dwell_end = (cnt == sh_dwell);

    // Up-step at 33 bits so a wrap past 2^32 is seen as a carry and clamps to f_stop.
    assign sum_up   = {1'b0, Fword} + {1'b0, sh_step};
    assign up_clamp = sum_up[32] || (sum_up[31:0] >= sh_stop);

`ifdef SWEEP_DOWN_EN
    logic [32:0] diff_dn;
    logic        dn_clamp;
    logic        sweep_down;

    assign diff_dn      = {1'b0, Fword} - {1'b0, sh_step};
    assign dn_clamp     = diff_dn[32] || (diff_dn[31:0] <= sh_stop);
    assign sweep_down   = (sh_start > sh_stop);
    assign restart_last = (sh_start == sh_stop);

    always_comb begin
        next_word  = sum_up[31:0];
        next_clamp = up_clamp;
        if (sweep_down) begin
            next_word  = diff_dn[31:0];
            next_clamp = dn_clamp;
        end
    end
`else
    assign restart_last = (sh_start >= sh_stop);

    always_comb begin
        next_word  = sum_up[31:0];
        next_clamp = up_clamp;
    end
`endif

    // start is a level request: it is accepted only in IDLE with abort low, the config is
    // captured on that edge, and the sweep begins one edge later (start_q marks the gap).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            start_q  <= 1'b0;
            cnt      <= '0;
            Fword    <= '0;
            Pword    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            wrap     <= 1'b0;
            sh_start <= '0;
            sh_stop  <= '0;
            sh_step  <= '0;
            sh_dwell <= '0;
            sh_mode  <= 1'b0;
            sh_pword <= '0;
        end else begin
            done <= 1'b0;
            wrap <= 1'b0;
            if (abort) begin
                state   <= IDLE;
                start_q <= 1'b0;
                busy    <= 1'b0;
                cnt     <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        start_q <= start && !start_q;
                        if (start && !start_q) begin
                            sh_start <= f_start;
                            sh_stop  <= f_stop;
                            sh_step  <= f_step;
                            sh_dwell <= dwell;
                            sh_mode  <= mode;
                            sh_pword <= p_word;
                        end
                        if (start_q) begin
                            Pword <= sh_pword;
                            busy  <= 1'b1;
                            cnt   <= '0;
                            if (restart_last) begin
                                Fword <= sh_stop;
                                state <= LAST;
                            end else begin
                                Fword <= sh_start;
                                state <= SWEEP;
                            end
                        end
                    end
                    SWEEP: begin
                        if (dwell_end) begin
                            cnt <= '0;
                            if (next_clamp) begin
                                Fword <= sh_stop;
                                state <= LAST;
                            end else begin
                                Fword <= next_word;
                            end
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    LAST: begin
                        if (dwell_end) begin
                            cnt <= '0;
                            if (!sh_mode) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                wrap <= 1'b1;
                                if (restart_last) begin
                                    Fword <= sh_stop;
                                    state <= LAST;
                                end else begin
                                    Fword <= sh_start;
                                    state <= SWEEP;
                                end
                            end
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
